// File: rtl/rcc_pkg.sv
// Shared types for the RCC clock monitor.
// Result cnt is sized for the widest supported counter; narrower instances use the low bits.
package rcc_pkg;

    localparam int CM_CNT_W_MAX = 16;

    typedef enum logic [1:0] {
        CM_IDLE,
        CM_SETTLE,
        CM_COUNT,
        CM_EVAL
    } clk_mon_state_e;

    typedef struct packed {
        logic [CM_CNT_W_MAX-1:0] cnt;
        logic                    too_slow;
        logic                    too_fast;
        logic                    stopped;
    } clk_mon_res_s;

endpackage

// File: rtl/rcc_sync_cell.sv
// Purpose: STAGES-deep single-bit synchronizer for an asynchronous level.
// Latency: STAGES clk_i cycles.
// Backpressure: none; free-running.
module rcc_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rcc_clk_mon.sv
// Purpose: counts mon_clk_i rising edges per window of clk_i cycles and flags slow/fast/stopped clocks.
// Latency: meas_vld_o win_len+1 cycles after COUNT entry; optional RCC_CLK_MON_STOP_DET_EN adds stop detection.
// Backpressure: none; results are pulses plus sticky flags cleared by clr_i.
module rcc_clk_mon
    import rcc_pkg::*;
#(
    parameter int WIN_W       = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int STOP_TO     = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mon_clk_i,
    input  logic             en_i,
    input  logic [WIN_W-1:0] win_len_i,
    input  logic [CNT_W-1:0] cnt_min_i,
    input  logic [CNT_W-1:0] cnt_max_i,
    input  logic             clr_i,
    output logic             busy_o,
    output logic             meas_vld_o,
    output logic [CNT_W-1:0] meas_cnt_o,
    output logic             too_slow_o,
    output logic             too_fast_o,
    output logic             stopped_o
);

    localparam int SET_W = $clog2(SYNC_STAGES + 2);

    clk_mon_state_e   state_q, state_nxt;
    logic [SET_W-1:0] settle_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             sync_q, sync_q_d, rise;
    logic             settle_done, win_last, load_win;
    logic             set_slow, set_fast, set_stop;
    logic             meas_vld_q;
    clk_mon_res_s     res_q;

    rcc_sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (mon_clk_i),
        .q     (sync_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q_d <= 1'b0;
        else       sync_q_d <= sync_q;
    end

    assign rise        = sync_q & ~sync_q_d;
    assign settle_done = (settle_cnt == SET_W'(SYNC_STAGES));
    assign win_last    = (win_cnt == WIN_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= CM_IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            CM_IDLE:   if (en_i) state_nxt = CM_SETTLE;
            CM_SETTLE: if (!en_i) state_nxt = CM_IDLE;
                       else if (settle_done) state_nxt = CM_COUNT;
            CM_COUNT:  if (!en_i) state_nxt = CM_IDLE;
                       else if (win_last) state_nxt = CM_EVAL;
            CM_EVAL:   state_nxt = en_i ? CM_COUNT : CM_IDLE;
            default:   state_nxt = CM_IDLE;
        endcase
    end

    // Both SETTLE->COUNT and EVAL->COUNT start a fresh window with win_len_i re-sampled.
    assign load_win = (state_nxt == CM_COUNT) && (state_q != CM_COUNT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            settle_cnt <= '0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
        end else begin
            settle_cnt <= (state_q == CM_SETTLE && state_nxt == CM_SETTLE) ? settle_cnt + 1'b1 : '0;
            if (load_win) begin
                win_cnt  <= (win_len_i == '0) ? WIN_W'(1) : win_len_i;
                edge_cnt <= '0;
            end else if (state_q == CM_COUNT) begin
                win_cnt <= win_cnt - 1'b1;
                if (rise && edge_cnt != '1) edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

    assign set_slow = (state_q == CM_EVAL) && (edge_cnt < cnt_min_i);
    assign set_fast = (state_q == CM_EVAL) && (edge_cnt > cnt_max_i);

`ifdef RCC_CLK_MON_STOP_DET_EN
    localparam int STOP_W = $clog2(STOP_TO + 1);
    logic [STOP_W-1:0] stop_cnt;
    logic              stop_run;

    assign stop_run = (state_q == CM_COUNT) || (state_q == CM_EVAL);

    always_ff @(posedge clk_i) begin
        if (rst_i || !stop_run || rise) stop_cnt <= '0;
        else if (stop_cnt != STOP_W'(STOP_TO)) stop_cnt <= stop_cnt + 1'b1;
    end

    // Keeps asserting while the clock stays dead, so clr_i cannot hide an ongoing stop.
    assign set_stop = stop_run && !rise && (stop_cnt >= STOP_W'(STOP_TO - 1));
`else
    assign set_stop = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q      <= '0;
            meas_vld_q <= 1'b0;
        end else begin
            meas_vld_q <= (state_q == CM_EVAL);
            if (state_q == CM_EVAL) res_q.cnt <= CM_CNT_W_MAX'(edge_cnt);
            res_q.too_slow <= (res_q.too_slow & ~clr_i) | set_slow;
            res_q.too_fast <= (res_q.too_fast & ~clr_i) | set_fast;
            res_q.stopped  <= (res_q.stopped  & ~clr_i) | set_stop;
        end
    end

    assign busy_o     = (state_q != CM_IDLE);
    assign meas_vld_o = meas_vld_q;
    assign meas_cnt_o = res_q.cnt[CNT_W-1:0];
    assign too_slow_o = res_q.too_slow;
    assign too_fast_o = res_q.too_fast;
    assign stopped_o  = res_q.stopped;

endmodule

// File: tb/tb_rcc_clk_mon.sv
// Scoreboard bench for rcc_clk_mon: window descriptors are queued at stimulus time and a
// negedge monitor derives the expected count from recorded mon_clk rise times.
`timescale 1ns/1ps
module tb_rcc_clk_mon;

    localparam int SYNC = 2;
`ifdef RCC_CLK_MON_STOP_DET_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic        mon_clk = 1'b0;
    logic [15:0] win_len, cnt_min, cnt_max, meas_cnt;
    logic        busy, meas_vld, too_slow, too_fast, stopped;

    logic        s_en, s_clr;
    logic [15:0] s_win;
    logic [3:0]  s_min, s_max, s_cnt;
    logic        s_busy, s_vld, s_slow, s_fast, s_stop;

    always #5 clk = ~clk;

    rcc_clk_mon #(.WIN_W(16), .CNT_W(16), .SYNC_STAGES(SYNC), .STOP_TO(64)) u_dut (
        .clk_i(clk), .rst_i(rst), .mon_clk_i(mon_clk), .en_i(en), .win_len_i(win_len),
        .cnt_min_i(cnt_min), .cnt_max_i(cnt_max), .clr_i(clr), .busy_o(busy),
        .meas_vld_o(meas_vld), .meas_cnt_o(meas_cnt), .too_slow_o(too_slow),
        .too_fast_o(too_fast), .stopped_o(stopped)
    );

    rcc_clk_mon #(.WIN_W(16), .CNT_W(4), .SYNC_STAGES(SYNC), .STOP_TO(64)) u_sat (
        .clk_i(clk), .rst_i(rst), .mon_clk_i(mon_clk), .en_i(s_en), .win_len_i(s_win),
        .cnt_min_i(s_min), .cnt_max_i(s_max), .clr_i(s_clr), .busy_o(s_busy),
        .meas_vld_o(s_vld), .meas_cnt_o(s_cnt), .too_slow_o(s_slow),
        .too_fast_o(s_fast), .stopped_o(s_stop)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Edge index n is the n-th rising clk edge; cyc holds the index of the latest edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitored clock: period mon_per clk cycles (0 = held low), changes on negedge.
    int mon_per = 0;
    always @(negedge clk) mon_clk <= (mon_per > 0) && ((cyc % mon_per) < (mon_per / 2));

    // Rise times: edge index at which the reference clock first sees mon_clk high.
    int   rises[$];
    logic mon_prev = 1'b0;
    always @(posedge clk) begin
        if (mon_clk && !mon_prev) rises.push_back(cyc + 1);
        mon_prev <= mon_clk;
    end

    // A rise seen at edge k is usable SYNC edges later; a window entered at edge e
    // with length wp owns the edges e+1 .. e+wp.
    function automatic int count_rises(input int lo, input int hi);
        int n = 0;
        foreach (rises[i])
            if (rises[i] + SYNC >= lo && rises[i] + SYNC <= hi) n++;
        return n;
    endfunction

    typedef struct {
        int e;
        int wp;
        int mn;
        int mx;
    } win_t;

    win_t sb[$];
    logic m_slow = 1'b0, m_fast = 1'b0, m_stop = 1'b0;
    int   m_cnt = 0;

    always @(negedge clk) begin
        win_t w;
        int   c;
        if (!rst && meas_vld) begin
            chk("vld_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                w = sb.pop_front();
                c = count_rises(w.e + 1, w.e + w.wp);
                if (c > 65535) c = 65535;
                chk("vld_cycle", cyc, w.e + w.wp + 1);
                chk("meas_cnt", meas_cnt, c);
                m_cnt = c;
                if (c < w.mn) m_slow = 1'b1;
                if (c > w.mx) m_fast = 1'b1;
                chk("too_slow", too_slow, m_slow);
                chk("too_fast", too_fast, m_fast);
                chk("stopped", stopped, m_stop);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    // abort_at < 0: last window completes and en drops during its EVAL.
    task automatic run(input int p, input int w, input int mn, input int mx, input int nwin,
                       input int abort_at, input bit clr_eval);
        int wp, a, e0, el;
        mon_per = p;
        repeat (8) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_slow = 1'b0; m_fast = 1'b0; m_stop = 1'b0;
        chk("clr_idle_slow", too_slow, 0);
        chk("clr_idle_fast", too_fast, 0);
        chk("clr_idle_stop", stopped, 0);
        win_len = 16'(w); cnt_min = 16'(mn); cnt_max = 16'(mx);
        wp = (w == 0) ? 1 : w;
        en = 1'b1;
        a  = cyc + 1;
        e0 = a + SYNC + 1;
        el = e0 + (nwin - 1) * (wp + 1);
        for (int j = 0; j < nwin; j++)
            if (abort_at < 0 || j < nwin - 1)
                sb.push_back(win_t'{e0 + j * (wp + 1), wp, mn, mx});
        if (p == 0) begin
            wait_cyc(e0 + 63);
            chk("stop_before_to", stopped, 0);
            wait_cyc(e0 + 64);
            chk("stop_at_to", stopped, STOP_EN);
            m_stop = STOP_EN;
        end
        if (abort_at >= 0) begin
            wait_cyc(el + abort_at);
            en = 1'b0;
            tick(); tick();
            chk("abort_idle", busy, 0);
            chk("abort_cnt_kept", meas_cnt, m_cnt);
        end else begin
            wait_cyc(el + wp);
            en  = 1'b0;
            clr = clr_eval;
            tick();
            clr = 1'b0;
            if (clr_eval) begin
                m_slow = 1'b0; m_fast = 1'b0; m_stop = 1'b0;
            end
            tick();
            chk("idle_after_eval", busy, 0);
        end
        repeat (4) tick();
        chk("sb_drained", sb.size(), 0);
        chk("end_cnt", meas_cnt, m_cnt);
        chk("end_slow", too_slow, m_slow);
        chk("end_fast", too_fast, m_fast);
        chk("end_stop", stopped, m_stop);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int p, w, nom, nw, ab, mn, mx;
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        win_len = '0; cnt_min = '0; cnt_max = '0;
        s_en = 1'b0; s_clr = 1'b0; s_win = '0; s_min = '0; s_max = '0;
        repeat (4) tick();
        chk("rst_busy", busy, 0);
        chk("rst_vld", meas_vld, 0);
        chk("rst_cnt", meas_cnt, 0);
        chk("rst_flags", {too_slow, too_fast, stopped}, 0);
        rst = 1'b0;
        tick();

        run(4, 100, 24, 26, 1, -1, 1'b0);
        chk("nominal_flags", {too_slow, too_fast}, 0);
        run(0, 50, 1, 5, 2, -1, 1'b0);
        chk("held_low_slow", too_slow, 1);
        run(4, 100, 0, 10, 1, -1, 1'b0);
        run(4, 100, 0, 10, 1, -1, 1'b1);
        chk("clr_in_eval_fast", too_fast, 1);
        run(4, 100, 20, 30, 1, 40, 1'b0);

        mon_per = 4;
        repeat (8) tick();
        win_len = 16'd100; cnt_min = 16'd0; cnt_max = 16'd5; en = 1'b1;
        repeat (40) tick();
        chk("busy_before_rst", busy, 1);
        rst = 1'b1; en = 1'b0;
        tick();
        sb.delete();
        m_slow = 1'b0; m_fast = 1'b0; m_stop = 1'b0; m_cnt = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_vld", meas_vld, 0);
        chk("midrst_cnt", meas_cnt, 0);
        chk("midrst_flags", {too_slow, too_fast, stopped}, 0);
        rst = 1'b0;
        tick();

        s_win = 16'd200; s_min = 4'd0; s_max = 4'd14; s_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            if (s_vld) got = 1'b1;
        end
        chk("sat_vld_seen", got, 1);
        chk("sat_cnt", s_cnt, 15);
        chk("sat_fast", s_fast, 1);
        chk("sat_slow", s_slow, 0);
        s_en = 1'b0;
        tick();

        run(5, 0, 0, 0, 6, -1, 1'b0);

        for (int r = 0; r < 14; r++) begin
            p   = $urandom_range(3, 12);
            w   = $urandom_range(0, 150);
            nw  = $urandom_range(1, 3);
            nom = ((w == 0) ? 1 : w) / p;
            mn  = $urandom_range(0, nom + 2);
            mx  = $urandom_range((nom > 2) ? nom - 2 : 0, nom + 3);
            ab  = -1;
            if ($urandom_range(0, 3) == 0 && w > 1) ab = $urandom_range(0, w - 1);
            run(p, w, mn, mx, nw, ab, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
